// File: rtl/loader_pkg.sv
// Shared types and constants for the picoMIPS program loader.
// Imported by the loader FSM and its byte packer.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] HEADER = 8'hA5;

  function automatic int bpw(input int isize);
    return isize / 8;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes MSB-first into an Isize-bit word and flags the
// byte that completes it; word already includes the current byte.
module byte_packer
  import loader_pkg::*;
#(
  parameter int Isize = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic [7:0]       din,
  output logic [Isize-1:0] word,
  output logic             word_full
);

  localparam int BPW = bpw(Isize);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [Isize-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [Isize+7:0] cat;

  assign cat       = {sreg, din};
  assign word      = cat[Isize-1:0];
  assign word_full = shift && (cnt == CW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= word;
      cnt  <= word_full ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader that writes picoMIPS program memory
// and holds the CPU in reset until a verified image is present.
module prog_loader
  import loader_pkg::*;
#(
  parameter int Psize = 6,
  parameter int Isize = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             we,
  output logic [Psize-1:0] waddr,
  output logic [Isize-1:0] wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  state_t           state, state_d;
  logic [Psize-1:0] last_idx, idx;
  logic [7:0]       sum, sum_d;
  logic             rdy_en, acc, hdr;
  logic             shift, clr;
  logic [Isize-1:0] word;
  logic             word_full;

  // The write cycle doubles as the per-word stall.
  assign rx_ready = rdy_en & ~we;
  assign acc      = rx_valid & rx_ready;
  assign hdr      = (rx_data == HEADER);
  assign sum_d    = sum + rx_data;
  assign cpu_hold = ~done;

  byte_packer #(.Isize(Isize)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .shift    (shift),
    .din      (rx_data),
    .word     (word),
    .word_full(word_full)
  );

  always_comb begin
    state_d = state;
    shift   = 1'b0;
    clr     = 1'b0;
    if (acc) begin
      unique case (state)
        IDLE, DONE, ERR: if (hdr) state_d = COUNT;
        COUNT: begin
          clr     = 1'b1;
          state_d = DATA;
        end
        DATA: begin
          shift = 1'b1;
          if (word_full && idx == last_idx) state_d = CHECK;
        end
        CHECK: state_d = (sum_d == 8'd0) ? DONE : ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rdy_en   <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      last_idx <= '0;
      idx      <= '0;
      sum      <= '0;
    end else begin
      state  <= state_d;
      rdy_en <= 1'b1;
      we     <= 1'b0;
      if (acc) begin
        unique case (state)
          IDLE, DONE, ERR: begin
            if (hdr) begin
              sum   <= '0;
              done  <= 1'b0;
              error <= 1'b0;
            end
          end
          COUNT: begin
            last_idx <= rx_data[Psize-1:0];
            idx      <= '0;
            sum      <= sum_d;
          end
          DATA: begin
            sum <= sum_d;
            if (word_full) begin
              we    <= 1'b1;
              waddr <= idx;
              wdata <= word;
              // Hold at the last index so a full image never wraps.
              if (idx != last_idx) idx <= idx + 1'b1;
            end
          end
          CHECK: begin
            sum   <= sum_d;
            done  <= (sum_d == 8'd0);
            error <= (sum_d != 8'd0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, bad checksum,
// gaps, full image, reload and reset mid-load.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, we, cpu_hold, done, error;
  logic [5:0]  waddr;
  logic [23:0] wdata;

  prog_loader #(.Psize(6), .Isize(24)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int wr_n = 0;
  int base;
  logic [5:0]  wr_addr [256];
  logic [23:0] wr_data [256];
  logic [23:0] img [64];

  always @(negedge clk) begin
    if (we && wr_n < 256) begin
      wr_addr[wr_n] = waddr;
      wr_data[wr_n] = wdata;
      wr_n++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 8 && !ok; t++) begin
      ok = rx_ready;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("rx_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_frame(input int c, input bit bad, input bit gaps);
    logic [7:0] s, b, k;
    s = 8'(c);
    send_byte(8'hA5, gaps);
    send_byte(8'(c), gaps);
    for (int w = 0; w <= c; w++) begin
      for (int j = 2; j >= 0; j--) begin
        b = img[w][8*j +: 8];
        s = s + b;
        send_byte(b, gaps);
      end
    end
    k = 8'd0 - s;
    if (bad) k = k + 8'd1;
    send_byte(k, gaps);
  endtask

  task automatic check_writes(input int from, input int n);
    check("wr_count", 32'(wr_n - from), 32'(n));
    for (int i = 0; i < n && from + i < 256; i++) begin
      check("waddr", 32'(wr_addr[from+i]), 32'(i));
      check("wdata", 32'(wr_data[from+i]), 32'(img[i]));
    end
  endtask

  task automatic check_reset_outs();
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with valid asserted
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      check_reset_outs();
    end
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(rx_ready), 32'd1);

    // 2: good two-word load
    img[0] = 24'h123456;
    img[1] = 24'hABCDEF;
    base = wr_n;
    send_frame(1, 1'b0, 1'b0);
    check_writes(base, 2);
    check("good_done", 32'(done), 32'd1);
    check("good_hold", 32'(cpu_hold), 32'd0);
    check("good_error", 32'(error), 32'd0);

    // 3: bad checksum (restarts from DONE)
    base = wr_n;
    send_frame(1, 1'b1, 1'b0);
    check_writes(base, 2);
    check("bad_error", 32'(error), 32'd1);
    check("bad_hold", 32'(cpu_hold), 32'd1);
    check("bad_done", 32'(done), 32'd0);

    // 4: garbage then gappy frame
    base = wr_n;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h7E, 1'b0);
    check("garbage_no_we", 32'(wr_n - base), 32'd0);
    check("garbage_error", 32'(error), 32'd1);
    send_frame(1, 1'b0, 1'b1);
    check_writes(base, 2);
    check("gap_done", 32'(done), 32'd1);
    check("gap_hold", 32'(cpu_hold), 32'd0);
    check("gap_error", 32'(error), 32'd0);

    // 5: full 64-word image
    for (int i = 0; i < 64; i++) img[i] = 24'(i);
    base = wr_n;
    send_frame(63, 1'b0, 1'b0);
    check_writes(base, 64);
    check("full_done", 32'(done), 32'd1);
    check("full_hold", 32'(cpu_hold), 32'd0);

    // 6: reload, then reset after four payload bytes
    send_byte(8'hA5, 1'b0);
    check("reload_hold", 32'(cpu_hold), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    base = wr_n;
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check("mid_wr_count", 32'(wr_n - base), 32'd1);
    check("mid_wdata", 32'(wr_data[base]), 32'h112233);
    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (4) begin
      @(negedge clk);
      check_reset_outs();
    end
    check("mid_no_we", 32'(wr_n - base), 32'd1);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst2", 32'(rx_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
